// File: rtl/reveal_sequencer.sv
// Reveal datapath sequencer: bomb check, iterative flood-fill (one sweep per
// cycle until the revealed set is stable), then win/lose evaluation.
module reveal_sequencer #(
  parameter int unsigned GRID_SIZE = 3,
  parameter int unsigned IDX_W     = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               clear,
  input  logic                               start,
  input  logic [IDX_W-1:0]                   cur_x,
  input  logic [IDX_W-1:0]                   cur_y,
  input  logic [GRID_SIZE*GRID_SIZE-1:0]     bomb_grid,
  output logic [GRID_SIZE*GRID_SIZE-1:0]     reveal_grid,
  output logic [3:0]                         cur_count,
  output logic                               busy,
  output logic                               done,
  output logic                               win,
  output logic                               lose
);

  localparam int unsigned CELLS = GRID_SIZE * GRID_SIZE;
  localparam int unsigned CW    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int unsigned ITW   = $clog2(CELLS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_EXPAND,
    S_EVAL,
    S_WIN,
    S_LOSE
  } state_e;

  state_e               state_q, state_d;
  logic [CELLS-1:0]     reveal_q, reveal_d;
  logic [CW-1:0]        idx_q, idx_d;
  logic [ITW-1:0]       iter_q, iter_d;
  logic                 done_q, done_d;
  logic                 win_q, win_d;
  logic                 lose_q, lose_d;

  logic [CELLS-1:0][3:0] cnt;
  logic [CELLS-1:0]      zero_c;
  logic [CELLS-1:0]      spread;
  logic [CELLS-1:0]      sweep;
  logic                  in_range;
  logic [CW-1:0]         cur_idx;

  // 8-neighbourhood without wrap-around, on linear cell indices.
  function automatic logic adjacent(input int unsigned a, input int unsigned b);
    int unsigned ax, ay, bx, by;
    ax = a % GRID_SIZE;
    ay = a / GRID_SIZE;
    bx = b % GRID_SIZE;
    by = b / GRID_SIZE;
    return (a != b) && (ax + 1 >= bx) && (bx + 1 >= ax)
                    && (ay + 1 >= by) && (by + 1 >= ay);
  endfunction

  always_comb begin
    cnt    = '0;
    zero_c = '0;
    spread = '0;
    for (int unsigned c = 0; c < CELLS; c++) begin
      for (int unsigned n = 0; n < CELLS; n++) begin
        if (adjacent(c, n)) cnt[c] = cnt[c] + {3'b000, bomb_grid[n]};
      end
    end
    for (int unsigned c = 0; c < CELLS; c++) begin
      zero_c[c] = (cnt[c] == 4'd0) && !bomb_grid[c];
    end
    for (int unsigned c = 0; c < CELLS; c++) begin
      for (int unsigned n = 0; n < CELLS; n++) begin
        if (adjacent(c, n) && reveal_q[n] && zero_c[n]) spread[c] = 1'b1;
      end
    end
  end

  assign sweep     = reveal_q | (spread & ~bomb_grid);
  assign in_range  = (32'(cur_x) < GRID_SIZE) && (32'(cur_y) < GRID_SIZE);
  assign cur_idx   = CW'(32'(cur_y) * GRID_SIZE + 32'(cur_x));
  assign cur_count = in_range ? cnt[cur_idx] : 4'd0;

  always_comb begin
    state_d  = state_q;
    reveal_d = reveal_q;
    idx_d    = idx_q;
    iter_d   = iter_q;
    done_d   = 1'b0;
    win_d    = win_q;
    lose_d   = lose_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!in_range) begin
            done_d = 1'b1;
          end else begin
            idx_d   = cur_idx;
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (bomb_grid[idx_q]) begin
          reveal_d = reveal_q | bomb_grid;
          lose_d   = 1'b1;
          state_d  = S_LOSE;
        end else if (reveal_q[idx_q]) begin
          state_d = S_EVAL;
        end else begin
          reveal_d[idx_q] = 1'b1;
          iter_d          = '0;
          state_d         = zero_c[idx_q] ? S_EXPAND : S_EVAL;
        end
      end
      S_EXPAND: begin
        reveal_d = sweep;
        iter_d   = iter_q + 1'b1;
        // Iteration cap is a safety net; a stable sweep normally ends first.
        if ((sweep == reveal_q) || (iter_q == ITW'(CELLS - 1))) state_d = S_EVAL;
      end
      S_EVAL: begin
        if (&(reveal_q | bomb_grid)) begin
          win_d   = 1'b1;
          state_d = S_WIN;
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WIN, S_LOSE: ;
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d  = S_IDLE;
      reveal_d = '0;
      done_d   = 1'b0;
      win_d    = 1'b0;
      lose_d   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      reveal_q <= '0;
      idx_q    <= '0;
      iter_q   <= '0;
      done_q   <= 1'b0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      reveal_q <= reveal_d;
      idx_q    <= idx_d;
      iter_q   <= iter_d;
      done_q   <= done_d;
      win_q    <= win_d;
      lose_q   <= lose_d;
    end
  end

  assign reveal_grid = reveal_q;
  assign done        = done_q;
  assign win         = win_q;
  assign lose        = lose_q;
  assign busy        = (state_q == S_CHECK) || (state_q == S_EXPAND) || (state_q == S_EVAL);

endmodule

// File: tb/tb_reveal_sequencer.sv
// Bench for reveal_sequencer: directed scenarios plus random games checked
// against a queue-based flood-fill reference model.
module tb_reveal_sequencer;

  localparam int N     = 3;
  localparam int CELLS = N * N;
  localparam int R_IGN  = 0;
  localparam int R_DONE = 1;
  localparam int R_WIN  = 2;
  localparam int R_LOSE = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       start = 1'b0;
  logic [3:0] cur_x = '0;
  logic [3:0] cur_y = '0;
  logic [8:0] bomb_grid = '0;
  logic [8:0] reveal_grid;
  logic [3:0] cur_count;
  logic       busy, done, win, lose;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] m_reveal = '0;
  bit         m_win    = 1'b0;
  bit         m_lose   = 1'b0;

  reveal_sequencer #(.GRID_SIZE(3), .IDX_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .start       (start),
    .cur_x       (cur_x),
    .cur_y       (cur_y),
    .bomb_grid   (bomb_grid),
    .reveal_grid (reveal_grid),
    .cur_count   (cur_count),
    .busy        (busy),
    .done        (done),
    .win         (win),
    .lose        (lose)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic bit adj(input int a, input int b);
    int dx, dy;
    dx = (a % N) - (b % N);
    dy = (a / N) - (b / N);
    return (a != b) && (dx >= -1) && (dx <= 1) && (dy >= -1) && (dy <= 1);
  endfunction

  function automatic int nb_count(input int c);
    int s = 0;
    for (int n = 0; n < CELLS; n++) if (adj(c, n) && bomb_grid[n]) s++;
    return s;
  endfunction

  function automatic bit is_zero(input int c);
    return (nb_count(c) == 0) && !bomb_grid[c];
  endfunction

  task automatic model_clear();
    m_reveal = '0;
    m_win    = 1'b0;
    m_lose   = 1'b0;
  endtask

  // Game rules at request granularity: outcome, final revealed set, latency.
  task automatic model_req(input int x, input int y, output int res, output int lat, output bit exact);
    int c;
    int q[$];
    int p;
    res = R_IGN; lat = 0; exact = 1'b1;
    if (m_win || m_lose) return;
    if (x >= N || y >= N) begin
      res = R_DONE;
      return;
    end
    c = y * N + x;
    if (bomb_grid[c]) begin
      m_reveal = m_reveal | bomb_grid;
      m_lose   = 1'b1;
      res      = R_LOSE;
      lat      = 1;
      return;
    end
    lat = 2;
    if (!m_reveal[c]) begin
      m_reveal[c] = 1'b1;
      if (is_zero(c)) begin
        exact = 1'b0;
        for (int i = 0; i < CELLS; i++) if (m_reveal[i] && is_zero(i)) q.push_back(i);
        while (q.size() > 0) begin
          p = q.pop_front();
          for (int n = 0; n < CELLS; n++) begin
            if (adj(p, n) && !bomb_grid[n] && !m_reveal[n]) begin
              m_reveal[n] = 1'b1;
              if (is_zero(n)) q.push_back(n);
            end
          end
        end
      end
    end
    if (&(m_reveal | bomb_grid)) begin
      m_win = 1'b1;
      res   = R_WIN;
    end else begin
      res = R_DONE;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
    check_eq("clear_reveal", 32'(reveal_grid), 32'(0));
    check_eq("clear_flags", {29'd0, done, win, lose}, 32'(0));
    check_eq("clear_busy", 32'(busy), 32'(0));
  endtask

  task automatic do_request(input int x, input int y, output int res);
    int  lat, k;
    bit  exact, found, busy_ok;
    cur_x = x[3:0];
    cur_y = y[3:0];
    #1;
    if (x < N && y < N) check_eq("cur_count", 32'(cur_count), 32'(nb_count(y * N + x)));
    model_req(x, y, res, lat, exact);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (res == R_IGN) begin
      check_eq("ignored_busy", 32'(busy), 32'(0));
      tick();
      check_eq("ignored_reveal", 32'(reveal_grid), 32'(m_reveal));
      check_eq("ignored_flags", {29'd0, done, win, lose}, {29'd0, 1'b0, m_win, m_lose});
      return;
    end
    k = 0; found = 1'b0; busy_ok = 1'b1;
    while (!found && k <= 20) begin
      if (done || win || lose) found = 1'b1;
      else begin
        if (!busy) busy_ok = 1'b0;
        tick();
        k++;
      end
    end
    check_eq("finished", 32'(found), 32'(1));
    check_eq("busy_while_working", 32'(busy_ok), 32'(1));
    check_eq("outcome", {29'd0, done, win, lose},
             {29'd0, res == R_DONE, res == R_WIN, res == R_LOSE});
    check_eq("reveal", 32'(reveal_grid), 32'(m_reveal));
    if (exact) check_eq("latency", 32'(k), 32'(lat));
    else       check_eq("latency_bound", 32'(k <= 2 + CELLS), 32'(1));
    check_eq("busy_after", 32'(busy), 32'(0));
    if (res == R_DONE) begin
      tick();
      check_eq("done_pulse", 32'(done), 32'(0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int res;
    tick();
    tick();
    check_eq("reset_reveal", 32'(reveal_grid), 32'(0));
    check_eq("reset_flags", {28'd0, busy, done, win, lose}, 32'(0));
    reset = 1'b1;
    tick();

    // Flood-fill from the far corner wins.
    bomb_grid = 9'b000000001;
    do_clear();
    do_request(2, 2, res);
    check_eq("t1_res", 32'(res), 32'(R_WIN));
    check_eq("t1_reveal", 32'(reveal_grid), 32'(9'b111111110));

    // Bomb hit, then start ignored, then clear.
    do_clear();
    do_request(0, 0, res);
    check_eq("t2_reveal", 32'(reveal_grid), 32'(9'b000000001));
    do_request(1, 1, res);
    do_clear();

    // Single non-zero cell.
    bomb_grid = 9'b000010000;
    do_clear();
    cur_x = 4'd0; cur_y = 4'd0;
    #1;
    check_eq("t3_count", 32'(cur_count), 32'(1));
    do_request(0, 0, res);
    check_eq("t3_reveal", 32'(reveal_grid), 32'(9'b000000001));

    // Out-of-range cursor.
    do_request(3, 0, res);
    check_eq("t4_reveal", 32'(reveal_grid), 32'(9'b000000001));

    // Clear one cycle into EXPAND.
    bomb_grid = 9'b000000001;
    do_clear();
    cur_x = 4'd2; cur_y = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_eq("t5_expand_busy", 32'(busy), 32'(1));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
    check_eq("t5_reveal", 32'(reveal_grid), 32'(0));
    check_eq("t5_flags", {28'd0, busy, done, win, lose}, 32'(0));
    do_request(1, 1, res);

    // Reset during EXPAND with clear high.
    do_clear();
    cur_x = 4'd2; cur_y = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b0;
    clear = 1'b1;
    tick();
    check_eq("t6_reveal", 32'(reveal_grid), 32'(0));
    check_eq("t6_flags", {28'd0, busy, done, win, lose}, 32'(0));
    reset = 1'b1;
    clear = 1'b0;
    model_clear();
    do_request(2, 2, res);

    // Random games.
    for (int g = 0; g < 40; g++) begin
      logic [8:0] b;
      for (int i = 0; i < CELLS; i++) b[i] = ($urandom_range(0, 5) == 0);
      bomb_grid = b;
      do_clear();
      for (int r = 0; r < 8; r++) begin
        do_request(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), res);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reveal_sequencer.md
Name: reveal_sequencer

Overview:
- Sequences the cell-reveal datapath of the minesweeper game.
- On a reveal request at the cursor cell it first checks for a bomb. If the cell is safe and has zero adjacent bombs, it flood-fills iteratively, one sweep per cycle, until the revealed set stops changing.
- It then evaluates win/lose.
- Sits between the game FSM (reveal request, cursor, bomb grid) and the display, which consumes reveal_grid.

Parameters:
- GRID_SIZE, 3, grid edge length N; the grid has N*N cells.
- IDX_W, 4, width of cursor coordinates; must satisfy 2^IDX_W > GRID_SIZE.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- clear  in  1  restart: empties the revealed set and returns to IDLE.
- start  in  1  reveal request; level-sampled, accepted only in IDLE.
- cur_x  in  IDX_W  cursor column, 0..N-1.
- cur_y  in  IDX_W  cursor row, 0..N-1.
- bomb_grid  in  N*N  bit (y*N+x) = 1 means bomb; must be held stable while busy.
- reveal_grid  out  N*N  revealed cells, registered.
- cur_count  out  4  adjacent-bomb count of the cursor cell, combinational.
- busy  out  1  high in every state except IDLE, WIN and LOSE.
- done  out  1  one-cycle registered pulse when a request completes without win or lose.
- win  out  1  sticky.
- lose  out  1  sticky.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state = IDLE.
  - reveal_grid, done, win, lose, busy all 0.
  - The iteration counter is cleared.
  - Reset overrides clear and start.
- clear==1 (reset high), in any state:
  - Next cycle: state = IDLE, reveal_grid = 0, win = lose = done = 0.
  - Overrides start, including mid-EXPAND.
- Neighbour count:
  - 8-neighbourhood of a cell; no wrap-around at edges.
  - Counts are 0..8 in 4 bits, combinational from bomb_grid.
  - count_zero[c] = (count[c] == 0) and bomb_grid[c] == 0.
- IDLE, start==1:
  - Cursor out of range (cur_x >= N or cur_y >= N): stay in IDLE, no change to reveal_grid, done=1 next cycle.
  - Otherwise latch idx = cur_y*N + cur_x and go to CHECK.
- CHECK (1 cycle):
  - bomb_grid[idx]: reveal_grid <= reveal_grid | bomb_grid; lose <= 1; go to LOSE.
  - Else, cell already revealed: go to EVAL with no change.
  - Else: reveal_grid[idx] <= 1; go to EXPAND if count_zero[idx], otherwise go to EVAL.
- EXPAND (one sweep per cycle):
  - next[c] = reveal[c] | (!bomb[c] & any 8-neighbour n with reveal[n] & count_zero[n]).
  - reveal_grid <= next.
  - If next == reveal_grid, or the iteration counter reaches N*N, go to EVAL. The counter starts at 0 on entry.
  - The N*N cap is a safety bound only; a correct sweep converges earlier.
- EVAL (1 cycle):
  - (reveal_grid | bomb_grid) all ones: win <= 1; go to WIN.
  - Otherwise done <= 1; go to IDLE.
- WIN / LOSE:
  - Terminal; start is ignored.
  - Only clear or reset leaves these states.
- Latency, safe non-zero cell:
  - start sampled at edge t.
  - reveal bit visible after edge t+1.
  - done high for the cycle following edge t+2.
- start held high:
  - One request per IDLE visit.
  - A request still high on re-entry to IDLE is accepted again; re-revealing an already-revealed cell is harmless.
- done, win and lose are never high in the same cycle.

Test Plan:
- N=3, bomb_grid=9'b000000001, reveal (2,2) -> flood-fill; reveal_grid=9'b111111110; win=1 within 3+N*N cycles; done stays 0.
- Same bombs, reveal (0,0) -> lose=1; reveal_grid=9'b000000001; a further start has no effect; clear -> reveal_grid=0, lose=0, IDLE.
- bomb_grid=9'b000010000 (centre), reveal (0,0) -> cur_count=1; reveal_grid=9'b000000001; done pulse exactly 1 cycle, 3 cycles after start.
- cur_x=3 with N=3 -> reveal_grid unchanged; done pulse next cycle; busy never asserted.
- Assert clear one cycle into EXPAND (bomb at index 0, reveal (2,2)) -> next cycle reveal_grid=0, state IDLE, win=0.
- reset low during EXPAND with clear high -> all outputs 0 next cycle; reset low wins over clear.
